dmem_arbiter: RTL and testbench

Two-port arbiter that shares the processor's single-port data memory between the CPU load/store port (m0) and the program-loader/debug port (m1). It sits between `topLevelModule`'s data-memory interface and the memory macro, which has a fixed read latency. The arbiter serialises requests, applies round-robin priority on ties, and returns one completion per accepted request. Misaligned accesses are rejected without touching memory.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/rr_pick2.sv | 12 +
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       any_o
);

  assign any_o    = |req_i;
  assign winner_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises the CPU (m0) and loader/debug (m1) ports onto a single-port
// data memory with fixed read latency; misaligned accesses never reach memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              owner_q, we_q, mis_q, last_q, err_q;
  logic [ADDR_W-3:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              winner, any, arb_ok, take;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req_i    ({m1_req, m0_req}),
    .last_i   (last_q),
    .winner_o (winner),
    .any_o    (any)
  );

  assign arb_ok    = (state_q == IDLE) || (state_q == RESP);
  assign take      = arb_ok && any;
  assign sel_we    = winner ? m1_we    : m0_we;
  assign sel_addr  = winner ? m1_addr  : m0_addr;
  assign sel_wdata = winner ? m1_wdata : m0_wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = any ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= PORT_M0;
      last_q  <= PORT_M1;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q <= winner;
        last_q  <= winner;
        we_q    <= sel_we;
        mis_q   <= (sel_addr[1:0] != 2'b00);
        addr_q  <= sel_addr[ADDR_W-1:2];
        wdata_q <= sel_wdata;
      end
      if (state_q == ISSUE) cnt_q <= CNT_W'(LATENCY - 1);
      if (state_q == WAIT) begin
        cnt_q <= cnt_q - 1'b1;
        // Writes and rejected accesses return zero data.
        if (cnt_q == '0) begin
          rdata_q <= (we_q || mis_q) ? '0 : mem_rdata;
          err_q   <= mis_q;
        end
      end
    end
  end

  logic is_iss, is_resp;
  assign is_iss  = (state_q == ISSUE);
  assign is_resp = (state_q == RESP);

  assign m0_gnt    = is_iss  && (owner_q == PORT_M0);
  assign m1_gnt    = is_iss  && (owner_q == PORT_M1);
  assign m0_rvalid = is_resp && (owner_q == PORT_M0);
  assign m1_rvalid = is_resp && (owner_q == PORT_M1);
  assign m0_rdata  = m0_rvalid ? rdata_q : '0;
  assign m1_rdata  = m1_rvalid ? rdata_q : '0;
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;

  assign mem_en    = is_iss && !mis_q;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a LATENCY=2 memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we, busy;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int nchk = 0;
  int nerr = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: read data is presented only in the cycle exactly two after mem_en.
  logic [31:0] mem [0:63];
  logic [1:0]  pv = '0;
  logic [5:0]  pa0 = '0, pa1 = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    pv  <= {pv[0], mem_en && !mem_we};
    pa0 <= mem_addr[5:0];
    pa1 <= pa0;
  end
  assign mem_rdata = pv[1] ? mem[pa1] : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs_or();
    return {18'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_en, mem_we,
            busy, |m0_rdata, |m1_rdata, |mem_addr, |mem_wdata};
  endfunction

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_en;
    logic [29:0] exp_maddr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic own_g, oth_g, own_v, oth_v, own_e, stray_en;
    logic [31:0] own_d;
    logic [1:0]  g;

    tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 30'd4};
    tbl[1] = '{1'b1, 1'b1, 32'h20, 32'h000000A5, 32'h0,        1'b0, 1'b1, 30'd8};
    tbl[2] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h000000A5, 1'b0, 1'b1, 30'd8};
    tbl[3] = '{1'b0, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1'b0, 30'd0};
    tbl[4] = '{1'b0, 1'b1, 32'h30, 32'h12345678, 32'h0,        1'b0, 1'b1, 30'd12};
    tbl[5] = '{1'b0, 1'b0, 32'h30, 32'h0,        32'h12345678, 1'b0, 1'b1, 30'd12};
    tbl[6] = '{1'b1, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1'b0, 30'd0};
    tbl[7] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 30'd4};

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;

    // Reset state
    #3;
    chk("reset_outputs", outs_or(), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("idle_outputs", outs_or(), 32'h0);

    // Table-driven single transactions, each launched from IDLE
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].port, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      tick();
      own_g = tbl[i].port ? m1_gnt : m0_gnt;
      oth_g = tbl[i].port ? m0_gnt : m1_gnt;
      chk($sformatf("v%0d_gnt", i), {31'd0, own_g}, 32'd1);
      chk($sformatf("v%0d_oth_gnt", i), {31'd0, oth_g}, 32'd0);
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, tbl[i].exp_en});
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, tbl[i].exp_en & tbl[i].we});
      if (tbl[i].exp_en) begin
        chk($sformatf("v%0d_mem_addr", i), {2'd0, mem_addr}, {2'd0, tbl[i].exp_maddr});
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].we ? tbl[i].wdata : 32'h0);
      end
      drive(tbl[i].port, 1'b0, 1'b0, 32'h0, 32'h0);
      stray_en = 1'b0;
      tick();
      stray_en |= mem_en;
      tick();
      stray_en |= mem_en;
      chk($sformatf("v%0d_early_rvalid", i), {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      tick();
      stray_en |= mem_en;
      own_v = tbl[i].port ? m1_rvalid : m0_rvalid;
      oth_v = tbl[i].port ? m0_rvalid : m1_rvalid;
      own_d = tbl[i].port ? m1_rdata  : m0_rdata;
      own_e = tbl[i].port ? m1_err    : m0_err;
      chk($sformatf("v%0d_stray_en", i), {31'd0, stray_en}, 32'd0);
      chk($sformatf("v%0d_rvalid", i), {31'd0, own_v}, 32'd1);
      chk($sformatf("v%0d_oth_rvalid", i), {31'd0, oth_v}, 32'd0);
      chk($sformatf("v%0d_rdata", i), own_d, tbl[i].exp_rdata);
      chk($sformatf("v%0d_err", i), {31'd0, own_e}, {31'd0, tbl[i].exp_err});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      tick();
      chk($sformatf("v%0d_back_idle", i), {31'd0, busy}, 32'd0);
    end

    // Continuous tie from reset: m0, m1, m0, m1 at 4-cycle spacing
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      g = {m1_gnt, m0_gnt};
      chk($sformatf("tie_c%0d_gnt", c), {30'd0, g},
          (c == 1 || c == 9) ? 32'd1 : (c == 5 || c == 13) ? 32'd2 : 32'd0);
      if (c == 4) chk("tie_m0_rdata", m0_rdata, 32'hDEADBEEF);
      if (c == 8) chk("tie_m1_rdata", m1_rdata, 32'h000000A5);
      if (c == 16) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    tick();
    chk("tie_idle", {31'd0, busy}, 32'd0);

    // Reset during WAIT of an m0 read drops the transaction
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    chk("rst_pre_gnt", {31'd0, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    tick();
    chk("rst_in_wait", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_async_clear", outs_or(), 32'h0);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    chk("rst_m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    m1_req = 1'b0;
    own_v = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      own_v |= m0_rvalid;
      if (c == 2) chk("rst_m1_rdata", m1_rdata, 32'h000000A5);
    end
    chk("rst_no_m0_rvalid", {31'd0, own_v}, 32'd0);

    // After reset a tie again goes to m0
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    chk("rst_tie_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    m1_req = 1'b0;
    for (int c = 0; c < 6; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
